// File: rtl/evenodd_seq_monitor.sv
// Passive sequence-integrity monitor for the even/odd counter: predicts the next value, flags match/err, tracks lock.
// Optional MON_STICKY_EN adds a sticky error flag output err_sticky.
module evenodd_seq_monitor #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic [2:0]       cnt_in,
  input  logic             cnt_valid,
  output logic [2:0]       exp_out,
  output logic             match,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
`ifdef MON_STICKY_EN
  ,
  output logic             err_sticky
`endif
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_e;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [2:0]       exp_q, exp_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] errcnt_q, errcnt_d;
  logic             hit;
  logic             checking;

  // Odd sequence steps 7 -> 0, not 7+2 -> 1; other cases wrap naturally mod 8.
  function automatic logic [2:0] nxt(input logic [2:0] v, input logic oe_i);
    if (oe_i) begin
      if (v[0]) nxt = (v == 3'd7) ? 3'd0 : v + 3'd2;
      else      nxt = v + 3'd1;
    end else begin
      nxt = v[0] ? v + 3'd1 : v + 3'd2;
    end
  endfunction

  assign hit      = (cnt_in == exp_q);
  assign checking = cnt_valid && (state_q != HUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      run_q    <= '0;
      exp_q    <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (!cnt_valid) begin
      state_d = HUNT;
      run_d   = '0;
    end else begin
      case (state_q)
        HUNT: begin
          state_d = TRACK;
          run_d   = '0;
        end
        TRACK: begin
          if (hit) begin
            run_d = run_q + 4'd1;
            if (run_d >= LOCK_RUN) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            state_d = TRACK;
            run_d   = '0;
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    exp_d    = cnt_valid ? nxt(cnt_in, oe) : exp_q;
    match_d  = checking && hit;
    err_d    = checking && !hit;
    locked_d = (state_d == LOCKED);
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != '1)) errcnt_d = errcnt_q + ERR_W'(1);
  end

  assign exp_out   = exp_q;
  assign match     = match_q;
  assign err       = err_q;
  assign locked    = locked_q;
  assign err_count = errcnt_q;

`ifdef MON_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb sticky_d = sticky_q | err_d;

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_evenodd_seq_monitor.sv
// Directed-vector scoreboard bench for evenodd_seq_monitor (LOCK_N=4, ERR_W=2).
module tb_evenodd_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       oe = 1'b0;
  logic [2:0] cnt_in = '0;
  logic       cnt_valid = 1'b0;
  logic [2:0] exp_out;
  logic       match;
  logic       err;
  logic       locked;
  logic [1:0] err_count;
`ifdef MON_STICKY_EN
  logic       err_sticky;
`endif

  evenodd_seq_monitor #(.LOCK_N(4), .ERR_W(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .oe        (oe),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .exp_out   (exp_out),
    .match     (match),
    .err       (err),
    .locked    (locked),
    .err_count (err_count)
`ifdef MON_STICKY_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] exp_out;
    logic       match;
    logic       err;
    logic       locked;
    logic [1:0] err_count;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_idx = 0;

  task automatic step(input logic r, input logic v, input logic o, input logic [2:0] c,
                      input logic [2:0] x, input logic m, input logic e, input logic l,
                      input logic [1:0] ec);
    exp_t t;
    @(negedge clk);
    rst = r; cnt_valid = v; oe = o; cnt_in = c;
    t.exp_out = x; t.match = m; t.err = e; t.locked = l; t.err_count = ec;
    sb.push_back(t);
  endtask

  always @(posedge clk) begin
    exp_t t;
    logic bad;
    #1;
    if (sb.size() > 0) begin
      t = sb.pop_front();
      n_tests++;
      bad = (exp_out !== t.exp_out) || (match !== t.match) || (err !== t.err) ||
            (locked !== t.locked) || (err_count !== t.err_count);
`ifdef MON_STICKY_EN
      if (err_sticky !== (t.err_count != 2'd0)) bad = 1'b1;
`endif
      if (bad) begin
        n_fail++;
        $display("FAIL vec%0d: got exp_out=%0d match=%0b err=%0b locked=%0b err_count=%0d, want %0d %0b %0b %0b %0d",
                 vec_idx, exp_out, match, err, locked, err_count,
                 t.exp_out, t.match, t.err, t.locked, t.err_count);
      end
      vec_idx++;
    end
  end

  initial begin
    //    rst v oe cnt   exp m e l ec
    step(1, 0, 0, 0,    0, 0, 0, 0, 0);
    step(1, 0, 0, 0,    0, 0, 0, 0, 0);
    // odd chain, lock on 4th match
    step(0, 1, 1, 0,    1, 0, 0, 0, 0);
    step(0, 1, 1, 1,    3, 1, 0, 0, 0);
    step(0, 1, 1, 3,    5, 1, 0, 0, 0);
    step(0, 1, 1, 5,    7, 1, 0, 0, 0);
    step(0, 1, 1, 7,    0, 1, 0, 1, 0);
    step(0, 1, 1, 0,    1, 1, 0, 1, 0);
    step(0, 1, 1, 1,    3, 1, 0, 1, 0);
    step(0, 1, 1, 3,    5, 1, 0, 1, 0);
    step(0, 1, 1, 5,    7, 1, 0, 1, 0);
    step(0, 1, 1, 7,    0, 1, 0, 1, 0);
    // inject error while locked, resync from the bad sample
    step(0, 1, 1, 4,    5, 0, 1, 0, 1);
    step(0, 1, 1, 5,    7, 1, 0, 0, 1);
    step(0, 1, 1, 7,    0, 1, 0, 0, 1);
    step(0, 1, 1, 0,    1, 1, 0, 0, 1);
    step(0, 1, 1, 1,    3, 1, 0, 1, 1);
    // gap while locked, resume without pulse, relock
    step(0, 0, 1, 0,    3, 0, 0, 0, 1);
    step(0, 1, 1, 3,    5, 0, 0, 0, 1);
    step(0, 1, 1, 5,    7, 1, 0, 0, 1);
    step(0, 1, 1, 7,    0, 1, 0, 0, 1);
    step(0, 1, 1, 0,    1, 1, 0, 0, 1);
    step(0, 1, 1, 1,    3, 1, 0, 1, 1);
    // reset while locked with valid input
    step(1, 1, 1, 3,    0, 0, 0, 0, 0);
    // saturating error count (ERR_W=2)
    step(0, 1, 1, 0,    1, 0, 0, 0, 0);
    step(0, 1, 1, 0,    1, 0, 1, 0, 1);
    step(0, 1, 1, 0,    1, 0, 1, 0, 2);
    step(0, 1, 1, 0,    1, 0, 1, 0, 3);
    step(0, 1, 1, 0,    1, 0, 1, 0, 3);
    step(0, 1, 1, 0,    1, 0, 1, 0, 3);
    step(0, 1, 1, 1,    3, 1, 0, 0, 3);
    // even chain
    step(1, 0, 0, 0,    0, 0, 0, 0, 0);
    step(0, 1, 0, 0,    2, 0, 0, 0, 0);
    step(0, 1, 0, 2,    4, 1, 0, 0, 0);
    step(0, 1, 0, 4,    6, 1, 0, 0, 0);
    step(0, 1, 0, 6,    0, 1, 0, 0, 0);
    step(0, 1, 0, 0,    2, 1, 0, 1, 0);
    // alternating oe
    step(1, 0, 0, 0,    0, 0, 0, 0, 0);
    step(0, 1, 1, 0,    1, 0, 0, 0, 0);
    step(0, 1, 0, 1,    2, 1, 0, 0, 0);
    step(0, 1, 1, 2,    3, 1, 0, 0, 0);
    step(0, 1, 0, 3,    4, 1, 0, 0, 0);
    step(0, 1, 1, 4,    5, 1, 0, 1, 0);
    @(negedge clk);
    cnt_valid = 1'b0;
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
